// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: loader states, error bit positions and memory sizing shared by instr_mem_loader.
// INSTR_LOADER_CHECKSUM_EN widens the error vector with a checksum-mismatch bit.
package instr_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_CHECKSUM = 2;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam int ERR_W = 3;
`else
    localparam int ERR_W = 2;
`endif

    localparam int DEF_DATA_WIDTH = 8;
    localparam int MEM_BYTES = 2 ** DEF_DATA_WIDTH;

endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: running modulo-2**W sum of image bytes, present only with INSTR_LOADER_CHECKSUM_EN.
`ifdef INSTR_LOADER_CHECKSUM_EN
module loader_checksum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         accumulate,
    input  logic [W-1:0] data,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (rst || clear) value_q <= '0;
        else if (accumulate) value_q <= value_q + data;
    end

    assign value = value_q;

endmodule
`endif

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams image bytes into instruction memory from address 0, holding the core in reset.
// INSTR_LOADER_CHECKSUM_EN adds a CHECK state consuming one trailing checksum byte.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     cpu_rst,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] byte_count,
    output logic [ERR_W-1:0]         err
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e AFTER_LAST = CHECK;
`else
    localparam state_e AFTER_LAST = DONE;
`endif

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     we_q, in_ready_q, cpu_rst_q, done_q;
    logic                     start_ok, beat, img_beat, at_end;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign beat     = in_valid && in_ready_q;
    assign img_beat = beat && state_q == LOAD;
    assign at_end   = &ptr_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    loader_checksum #(.W(DATA_WIDTH)) u_sum (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .accumulate (img_beat),
        .data       (in_data),
        .value      (sum)
    );
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (start_ok) begin
            state_d = LOAD;
            ptr_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
        end else if (img_beat) begin
            ptr_d = at_end ? ptr_q : ptr_q + DATA_WIDTH'(1);
            cnt_d = cnt_q + ADDRESS_WIDTH'(1);
            if (in_last) begin
                state_d             = AFTER_LAST;
                err_d[ERR_MISALIGN] = cnt_d[1:0] != 2'b00;
            end else if (at_end) begin
                state_d             = DONE;
                err_d[ERR_OVERFLOW] = 1'b1;
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        else if (beat && state_q == CHECK) begin
            state_d             = DONE;
            err_d[ERR_CHECKSUM] = in_data != sum;
        end
`endif
    end

    // Release lags entry into DONE by one cycle so the final byte is committed before the core runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            we_q       <= img_beat;
            in_ready_q <= state_d == LOAD || state_d == CHECK;
            cpu_rst_q  <= !(state_q == DONE && state_d == DONE);
            done_q     <= state_q == DONE && state_d == DONE;
            if (img_beat) begin
                waddr_q <= ADDRESS_WIDTH'(ptr_q);
                wdata_q <= in_data;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign byte_count = cnt_q;
    assign err        = err_q;

endmodule
